gl_fetch_stream: RTL and testbench

Parametrised command-stream fetch unit for the GL pipeline. Issues sequential word reads to the command BRAM and parses the returned words into framed commands: header word plus operand words, with start/end markers and byte length. A prefetch FIFO with a credit-limited read issue feeds a valid/ready interface to decode. Decode can stall without losing in-flight BRAM data.

---
 rtl/gl_fetch_stream.sv | 170 +++++++++++++++++
 tb/tb_gl_fetch_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gl_fetch_stream.sv
// Command-stream fetch: credit-limited BRAM reads, header/operand framing, prefetch FIFO to decode.
// Optional build macro GL_FETCH_SKIP_NOP_EN drops NOP (0x00) headers in the parser instead of delivering them.
module gl_fetch_stream #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] TEXT_START = '0,
  parameter int                RD_LAT     = 1,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_addr_sel,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] cmd_word,
  output logic              cmd_sop,
  output logic              cmd_eop,
  output logic [7:0]        cmd_len,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic              sop;
    logic              eop;
    logic [7:0]        len;
  } entry_t;

  function automatic logic [7:0] hdr_len(input logic [7:0] op);
    case (op)
      8'h03, 8'h04:                      hdr_len = 8'd16;
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18: hdr_len = 8'd68;
      8'h19:                             hdr_len = 8'd20;
      8'h1A:                             hdr_len = 8'd28;
      default:                           hdr_len = 8'd4;
    endcase
  endfunction

  state_t           state;
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count, count_next, outstanding;
  logic [7:0]       remaining, rem_new, parse_len;
  logic [RD_LAT-1:0] vld_sr;
  logic             ret, is_hdr, end_hit, skip, push, pop, issue_next;
  logic [7:0]       opcode;

  // Parser, FIFO handshake and credit decision for the next issue slot.
  always_comb begin
    ret        = vld_sr[RD_LAT-1];
    opcode     = mem_rdata[7:0];
    is_hdr     = (remaining == 8'd0);
    parse_len  = 8'd0;
    rem_new    = remaining - 8'd1;
    if (is_hdr) begin
      parse_len = hdr_len(opcode);
      rem_new   = (hdr_len(opcode) >> 2) - 8'd1;
    end else begin
      parse_len = 8'd0;
    end
`ifdef GL_FETCH_SKIP_NOP_EN
    skip = is_hdr && (opcode == 8'h00);
`else
    skip = 1'b0;
`endif
    end_hit    = ret && is_hdr && (opcode == 8'hFF) && (state == S_RUN);
    push       = ret && (state == S_RUN) && !skip;
    pop        = cmd_valid && cmd_ready;
    count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    issue_next = (state == S_RUN) && !end_hit &&
                 ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH);
  end

  // Return tracker: a read issued with mem_en comes back RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= mem_en;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  // Prefetch FIFO storage and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cmd_valid  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{word: mem_rdata, sop: is_hdr, eop: (rem_new == 8'd0), len: parse_len};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_next;
      cmd_valid  <= (count_next != '0);
    end
  end

  assign cmd_word = fifo_mem[rd_ptr].word;
  assign cmd_sop  = fifo_mem[rd_ptr].sop;
  assign cmd_eop  = fifo_mem[rd_ptr].eop;
  assign cmd_len  = fifo_mem[rd_ptr].len;

  // Control FSM with read issue, outstanding count and frame tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      mem_en      <= 1'b0;
      mem_addr    <= TEXT_START;
      outstanding <= '0;
      remaining   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_en      <= issue_next;
      outstanding <= outstanding + CNT_W'(issue_next) - CNT_W'(ret);
      if (mem_en) mem_addr <= mem_addr + ADDR_W'(4);
      if (ret && (state == S_RUN)) remaining <= rem_new;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            mem_addr    <= start_addr_sel ? start_addr : TEXT_START;
            outstanding <= '0;
            remaining   <= 8'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        S_RUN: begin
          if (end_hit) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Speculative reads past END still return; wait them out before DONE.
          if ((fifo_count == '0) && (outstanding == '0)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gl_fetch_stream.sv
// Directed bench for gl_fetch_stream with a latency-3 BRAM model and a word scoreboard.
module tb_gl_fetch_stream;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, start_addr_sel, cmd_ready;
  logic [31:0] start_addr, mem_addr, mem_rdata, cmd_word;
  logic        mem_en, cmd_valid, cmd_sop, cmd_eop, busy, done;
  logic [7:0]  cmd_len;

  gl_fetch_stream #(.ADDR_W(32), .DATA_W(32), .TEXT_START(32'h0000_0000),
                    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr_sel(start_addr_sel),
    .start_addr(start_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word), .cmd_sop(cmd_sop),
    .cmd_eop(cmd_eop), .cmd_len(cmd_len), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        sop;
    logic        eop;
    logic [7:0]  len;
  } ent_t;

  logic [31:0] mem_img [256];
  logic [31:0] dpipe [RD_LAT];
  logic [RD_LAT-1:0] vpipe = '0;
  int          out_cnt = 0, max_out = 0;
  logic        trk_clr = 1'b0;
  int          ready_mode = 1;
  ent_t        got_q[$], exp_q[$];
  logic [31:0] addr_q[$];
  int          n_checks = 0, n_pass = 0;

  // BRAM model plus bench-side count of reads in flight.
  always @(posedge clk) begin
    dpipe[0] <= mem_en ? mem_img[mem_addr[9:2]] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    vpipe   <= {vpipe[RD_LAT-2:0], mem_en};
    out_cnt <= out_cnt + int'(mem_en) - int'(vpipe[RD_LAT-1]);
    if (trk_clr) max_out <= 0;
    else if (out_cnt > max_out) max_out <= out_cnt;
  end
  assign mem_rdata = dpipe[RD_LAT-1];

  // Monitor: accepted words and issued addresses.
  always @(negedge clk) begin
    if (reset && cmd_valid && cmd_ready)
      got_q.push_back('{w: cmd_word, sop: cmd_sop, eop: cmd_eop, len: cmd_len});
    if (reset && mem_en) addr_q.push_back(mem_addr);
  end

  initial begin
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       cmd_ready = 1'b0;
        1:       cmd_ready = 1'b1;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic exp_cmd(input int widx, input int nw, input logic [7:0] len);
    for (int k = 0; k < nw; k++)
      exp_q.push_back('{w: mem_img[widx+k], sop: (k == 0), eop: (k == nw-1), len: len});
  endtask

  task automatic compare_seq(input string tag, input int base);
    int n;
    n = got_q.size() - base;
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check($sformatf("%s_w%0d_word", tag, i), got_q[base+i].w, exp_q[i].w);
      check($sformatf("%s_w%0d_sop", tag, i), 32'(got_q[base+i].sop), 32'(exp_q[i].sop));
      check($sformatf("%s_w%0d_eop", tag, i), 32'(got_q[base+i].eop), 32'(exp_q[i].eop));
      if (exp_q[i].sop)
        check($sformatf("%s_w%0d_len", tag, i), 32'(got_q[base+i].len), 32'(exp_q[i].len));
    end
  endtask

  task automatic do_start(input logic sel, input logic [31:0] a);
    @(posedge clk); #1;
    start = 1'b1; start_addr_sel = sel; start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (got_q.size() < target && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_words_timeout", 32'(got_q.size() >= target), 32'd1);
  endtask

  initial begin
    int gbase, abase, s1, s2, g1, g2;
    for (int i = 0; i < 256; i++) mem_img[i] = 32'hEEEE_EE05;
    mem_img[0] = 32'h0000_0103;
    for (int i = 1; i < 4; i++) mem_img[i] = 32'hA000_0000 + 32'(i);
    mem_img[4] = 32'hAB00_00FF;
    mem_img[16] = 32'h7700_0011;
    for (int i = 17; i < 33; i++) mem_img[i] = 32'h1000_0000 + 32'(i);
    mem_img[33] = 32'h0000_00FF;
    mem_img[64] = 32'h0000_0019; mem_img[69] = 32'h0000_001A;
    mem_img[76] = 32'h0100_0019; mem_img[81] = 32'h0100_001A;
    for (int i = 65; i < 69; i++) mem_img[i] = 32'hC000_0000 + 32'(i);
    for (int i = 70; i < 76; i++) mem_img[i] = 32'hC000_0000 + 32'(i);
    for (int i = 77; i < 81; i++) mem_img[i] = 32'hC000_0000 + 32'(i);
    for (int i = 82; i < 88; i++) mem_img[i] = 32'hC000_0000 + 32'(i);
    mem_img[88] = 32'h0000_00FF;
    mem_img[128] = 32'h5500_0000;
    mem_img[129] = 32'h0000_00FF;

    reset = 1'b0; start = 1'b0; start_addr_sel = 1'b0; start_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_word", cmd_word, 32'h0);
    check("rst_cmd_len", 32'(cmd_len), 32'd0);
    check("rst_sop_eop", 32'({cmd_sop, cmd_eop}), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    reset = 1'b1;

    // A: VERTEX + END from TEXT_START
    ready_mode = 1; gbase = got_q.size(); abase = addr_q.size();
    exp_q.delete(); exp_cmd(0, 4, 8'd16); exp_cmd(4, 1, 8'd4);
    do_start(1'b0, 32'h0000_0800);
    check("A_busy", 32'(busy), 32'd1);
    wait_done("A");
    compare_seq("A", gbase);
    check("A_first_addr", (addr_q.size() > abase) ? addr_q[abase] : 32'hFFFF_FFFF, 32'h0);

    // B: MULTMATRIX at 0x40 via start_addr
    gbase = got_q.size(); abase = addr_q.size();
    exp_q.delete(); exp_cmd(16, 17, 8'd68); exp_cmd(33, 1, 8'd4);
    do_start(1'b1, 32'h0000_0040);
    wait_done("B");
    compare_seq("B", gbase);
    check("B_first_addr", (addr_q.size() > abase) ? addr_q[abase] : 32'hFFFF_FFFF, 32'h40);

    // C: decode stall mid-stream, issue must stop and nothing may be lost
    gbase = got_q.size();
    do_start(1'b1, 32'h0000_0040);
    wait_words(gbase + 3);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1; s1 = addr_q.size(); g1 = got_q.size();
    repeat (10) @(posedge clk);
    #1; s2 = addr_q.size(); g2 = got_q.size();
    check("C_stall_no_issue", 32'(s2 - s1), 32'd0);
    check("C_stall_no_accept", 32'(g2 - g1), 32'd0);
    check("C_stall_valid", 32'(cmd_valid), 32'd1);
    check("C_stall_busy", 32'(busy), 32'd1);
    ready_mode = 1;
    wait_done("C");
    compare_seq("C", gbase);

    // D: random ready, VIEWPORT/FRUSTUM mix, credit bound
    trk_clr = 1'b1; @(posedge clk); #1; trk_clr = 1'b0;
    ready_mode = 2; gbase = got_q.size();
    exp_q.delete();
    exp_cmd(64, 5, 8'd20); exp_cmd(69, 7, 8'd28); exp_cmd(76, 5, 8'd20);
    exp_cmd(81, 7, 8'd28); exp_cmd(88, 1, 8'd4);
    do_start(1'b1, 32'h0000_0100);
    wait_done("D");
    compare_seq("D", gbase);
    check("D_max_outstanding_le_depth", 32'(max_out <= FIFO_DEPTH), 32'd1);

    // E: reset mid-run with reads in flight, then clean restart
    ready_mode = 0;
    do_start(1'b1, 32'h0000_0100);
    repeat (5) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    check("E_valid_after_rst", 32'(cmd_valid), 32'd0);
    check("E_busy_after_rst", 32'(busy), 32'd0);
    check("E_mem_en_after_rst", 32'(mem_en), 32'd0);
    check("E_addr_after_rst", mem_addr, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("E_no_stale_push", 32'(cmd_valid), 32'd0);
    ready_mode = 1; gbase = got_q.size(); abase = addr_q.size();
    exp_q.delete(); exp_cmd(0, 4, 8'd16); exp_cmd(4, 1, 8'd4);
    do_start(1'b0, 32'h0000_0100);
    wait_done("E");
    compare_seq("E", gbase);
    check("E_first_addr", (addr_q.size() > abase) ? addr_q[abase] : 32'hFFFF_FFFF, 32'h0);

    // F: NOP then END
    gbase = got_q.size();
    exp_q.delete();
`ifndef GL_FETCH_SKIP_NOP_EN
    exp_cmd(128, 1, 8'd4);
`endif
    exp_cmd(129, 1, 8'd4);
    do_start(1'b1, 32'h0000_0200);
    wait_done("F");
    compare_seq("F", gbase);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
